mux_fluxo_rr: RTL and testbench

//   Parametrised N:1 stream multiplexer with a registered output and valid/ready handshake.
//   - Selects one of CANAIS input channels of WIDTH bits each.
//   - Selection is either by external select (chave) or by internal round-robin arbitration.
//   - Sits between per-channel producers and a single shared consumer. Replaces the fixed

---
 rtl/mux_fluxo_rr_if.sv | 42 ++++
 rtl/mux_fluxo_rr.sv | 137 +++++++++++++
 tb/tb_mux_fluxo_rr.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_fluxo_rr_if.sv
// Stream bundle between CANAIS producers, the N:1 mux and one consumer.
// Latency: none (wires only); the mux registers the output side.
// Backpressure: in_ready/out_ready; in_last/out_last present only with MUX_PACOTE_EN.
interface mux_fluxo_rr_if #(
   parameter int WIDTH  = 4,
   parameter int CANAIS = 4
);
   localparam int SEL_W = $clog2(CANAIS);

   logic [CANAIS*WIDTH-1:0] in_dados;
   logic [CANAIS-1:0]       in_valid;
   logic [CANAIS-1:0]       in_ready;
   logic [SEL_W-1:0]        chave;
   logic [WIDTH-1:0]        out_dados;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_canal;
`ifdef MUX_PACOTE_EN
   logic [CANAIS-1:0]       in_last;
   logic                    out_last;
`endif

   // Producer/consumer side
   modport master (
      output in_dados, in_valid, chave, out_ready,
      input  in_ready, out_dados, out_valid, out_canal
`ifdef MUX_PACOTE_EN
      , output in_last
      , input  out_last
`endif
   );

   // Multiplexer side
   modport slave (
      input  in_dados, in_valid, chave, out_ready,
      output in_ready, out_dados, out_valid, out_canal
`ifdef MUX_PACOTE_EN
      , input  in_last
      , output out_last
`endif
   );
endinterface

// File: rtl/mux_fluxo_rr.sv
// N:1 stream mux, external select (MODO=0) or round-robin (MODO=1); MUX_PACOTE_EN adds packet lock.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle with out_ready high.
// Backpressure: output register reloads only when empty or drained; in_ready is one-hot or zero.
module mux_fluxo_rr #(
   parameter int WIDTH  = 4,
   parameter int CANAIS = 4,
   parameter int MODO   = 0
) (
   input  logic          clock,
   input  logic          reset_n,
   mux_fluxo_rr_if.slave bus
);
   localparam int SEL_W = $clog2(CANAIS);

   typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] dados_q, dados_d;
   logic [SEL_W-1:0] canal_q, canal_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             chave_ok;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic             carrega;
   logic             libera;
   logic             xfer;
   logic [SEL_W:0]   rr_soma;
   logic [SEL_W-1:0] rr_cand;

`ifdef MUX_PACOTE_EN
   // The locked channel is always the one that produced the last beat, i.e. canal_q.
   logic trava_q, trava_d;
   logic last_q, last_d;
`endif

   // A power-of-two channel count cannot be addressed out of range.
   if (CANAIS == (1 << SEL_W)) begin : g_chave_pot2
      assign chave_ok = 1'b1;
   end else begin : g_chave_lim
      assign chave_ok = ({1'b0, bus.chave} < (SEL_W+1)'(CANAIS));
   end

   // Grant selection: external select or first requester at/after ptr; an open packet overrides both.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_soma   = '0;
      rr_cand   = '0;
      if (MODO == 0) begin
         grant_vld = chave_ok;
         grant_idx = bus.chave;
      end else begin
         for (int k = 0; k < CANAIS; k++) begin
            rr_soma = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (rr_soma >= (SEL_W+1)'(CANAIS)) begin
               rr_soma = rr_soma - (SEL_W+1)'(CANAIS);
            end
            rr_cand = rr_soma[SEL_W-1:0];
            if (!grant_vld && bus.in_valid[rr_cand]) begin
               grant_vld = 1'b1;
               grant_idx = rr_cand;
            end
         end
      end
`ifdef MUX_PACOTE_EN
      if (trava_q) begin
         grant_vld = 1'b1;
         grant_idx = canal_q;
      end
`endif
   end

   // The register can take a word when empty or when its current word leaves this cycle.
   assign carrega      = (estado_q == VAZIO) | bus.out_ready;
   assign libera       = reset_n & carrega & grant_vld;
   assign bus.in_ready = libera ? (CANAIS'(1) << grant_idx) : '0;
   assign xfer         = libera & bus.in_valid[grant_idx];

   // Next state of the output register, data capture and round-robin pointer advance.
   always_comb begin
      estado_d = estado_q;
      dados_d  = dados_q;
      canal_d  = canal_q;
      ptr_d    = ptr_q;
`ifdef MUX_PACOTE_EN
      trava_d  = trava_q;
      last_d   = last_q;
`endif
      case (estado_q)
         VAZIO:   if (xfer) estado_d = CHEIO;
         CHEIO:   if (!xfer && bus.out_ready) estado_d = VAZIO;
         default: estado_d = VAZIO;
      endcase
      if (xfer) begin
         dados_d = bus.in_dados[grant_idx*WIDTH +: WIDTH];
         canal_d = grant_idx;
         if (MODO != 0) begin
            ptr_d = (grant_idx == SEL_W'(CANAIS-1)) ? '0 : grant_idx + SEL_W'(1);
         end
`ifdef MUX_PACOTE_EN
         last_d  = bus.in_last[grant_idx];
         trava_d = !bus.in_last[grant_idx];
`endif
      end
   end

   // State registers; reset drops any word in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= VAZIO;
         dados_q  <= '0;
         canal_q  <= '0;
         ptr_q    <= '0;
`ifdef MUX_PACOTE_EN
         trava_q  <= 1'b0;
         last_q   <= 1'b0;
`endif
      end else begin
         estado_q <= estado_d;
         dados_q  <= dados_d;
         canal_q  <= canal_d;
         ptr_q    <= ptr_d;
`ifdef MUX_PACOTE_EN
         trava_q  <= trava_d;
         last_q   <= last_d;
`endif
      end
   end

   assign bus.out_valid = (estado_q == CHEIO);
   assign bus.out_dados = dados_q;
   assign bus.out_canal = canal_q;
`ifdef MUX_PACOTE_EN
   assign bus.out_last  = last_q;
`endif
endmodule

// File: tb/tb_mux_fluxo_rr.sv
// Bench for mux_fluxo_rr: one MODO=0 and one MODO=1 instance share stimulus.
// Reference model tracks the output register, pointer and packet lock per instance.
// Directed scenarios first, then a randomized run; packet checks need MUX_PACOTE_EN.
module tb_mux_fluxo_rr;
   localparam int W = 4;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   mux_fluxo_rr_if #(.WIDTH(W), .CANAIS(N)) if0 ();
   mux_fluxo_rr_if #(.WIDTH(W), .CANAIS(N)) if1 ();

   mux_fluxo_rr #(.WIDTH(W), .CANAIS(N), .MODO(0)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
   mux_fluxo_rr #(.WIDTH(W), .CANAIS(N), .MODO(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));

   int checks   = 0;
   int failures = 0;

   // Stimulus shared by both instances
   logic [N*W-1:0] s_dados;
   logic [N-1:0]   s_vld;
   logic [1:0]     s_chave;
   logic           s_ordy;
   logic [N-1:0]   s_last;

   // Reference model state, index 0 = MODO 0, index 1 = MODO 1
   bit m_vld[2];
   int m_dat[2];
   int m_can[2];
   bit m_last[2];
   int m_ptr[2];
   bit m_lock[2];
   int m_lch[2];
   int e_rdy[2];
   bit e_xfer[2];
   int e_g[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      if0.in_dados = s_dados; if1.in_dados = s_dados;
      if0.in_valid = s_vld;   if1.in_valid = s_vld;
      if0.chave    = s_chave; if1.chave    = s_chave;
      if0.out_ready = s_ordy; if1.out_ready = s_ordy;
`ifdef MUX_PACOTE_EN
      if0.in_last = s_last;   if1.in_last = s_last;
`endif
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_vld[d] = 0; m_dat[d] = 0; m_can[d] = 0; m_last[d] = 0;
         m_ptr[d] = 0; m_lock[d] = 0; m_lch[d] = 0;
      end
   endtask

   // Which channel would be served now, and whether a word actually moves.
   task automatic model_pre();
      bit gv;
      int g;
      int c;
      for (int d = 0; d < 2; d++) begin
         gv = 0;
         g  = 0;
         if (m_lock[d]) begin
            gv = 1;
            g  = m_lch[d];
         end else if (d == 0) begin
            gv = (int'(s_chave) < N);
            g  = int'(s_chave);
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr[d] + k) % N;
               if (!gv && s_vld[c]) begin
                  gv = 1;
                  g  = c;
               end
            end
         end
         e_g[d]    = g;
         e_rdy[d]  = (gv && (!m_vld[d] || s_ordy) && reset_n) ? (1 << g) : 0;
         e_xfer[d] = (e_rdy[d] != 0) && s_vld[g];
      end
   endtask

   task automatic model_post();
      int g;
      for (int d = 0; d < 2; d++) begin
         g = e_g[d];
         if (e_xfer[d]) begin
            m_vld[d]  = 1;
            m_dat[d]  = int'(s_dados[g*W +: W]);
            m_can[d]  = g;
            if (d == 1) m_ptr[d] = (g + 1) % N;
`ifdef MUX_PACOTE_EN
            m_last[d] = s_last[g];
            m_lock[d] = !s_last[g];
            m_lch[d]  = g;
`endif
         end else if (s_ordy) begin
            m_vld[d] = 0;
         end
      end
   endtask

   task automatic check_outs();
      chk("m0_valid", 32'(if0.out_valid), 32'(m_vld[0]));
      chk("m0_dados", 32'(if0.out_dados), m_dat[0]);
      chk("m0_canal", 32'(if0.out_canal), m_can[0]);
      chk("m1_valid", 32'(if1.out_valid), 32'(m_vld[1]));
      chk("m1_dados", 32'(if1.out_dados), m_dat[1]);
      chk("m1_canal", 32'(if1.out_canal), m_can[1]);
`ifdef MUX_PACOTE_EN
      chk("m0_last", 32'(if0.out_last), 32'(m_last[0]));
      chk("m1_last", 32'(if1.out_last), 32'(m_last[1]));
`endif
   endtask

   // One clock: apply inputs at the falling edge, check in_ready, then outputs after the rising edge.
   task automatic cycle();
      drive();
      #1;
      model_pre();
      chk("m0_in_ready", 32'(if0.in_ready), e_rdy[0]);
      chk("m1_in_ready", 32'(if1.in_ready), e_rdy[1]);
      @(posedge clock);
      model_post();
      #1;
      check_outs();
      @(negedge clock);
   endtask

   // Reset asserted between edges must clear outputs and in_ready without waiting for a clock.
   task automatic do_reset_async();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_m0_valid", 32'(if0.out_valid), 0);
      chk("rst_m0_dados", 32'(if0.out_dados), 0);
      chk("rst_m0_ready", 32'(if0.in_ready), 0);
      chk("rst_m1_valid", 32'(if1.out_valid), 0);
      chk("rst_m1_ready", 32'(if1.in_ready), 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int exp_a[4];
      int exp_b[6];

      reset_n = 1'b0;
      s_dados = '0; s_vld = '0; s_chave = '0; s_ordy = 1'b0; s_last = '0;
      drive();
      model_reset();
      @(negedge clock);
      check_outs();
      chk("rst_init_ready", 32'(if0.in_ready), 0);
      reset_n = 1'b1;

      // External select picks channel 2
      s_chave = 2'd2; s_dados = 16'h0A00; s_vld = 4'b0100; s_ordy = 1'b1;
      cycle();
      chk("sel2_dados", 32'(if0.out_dados), 32'hA);
      chk("sel2_canal", 32'(if0.out_canal), 2);
      chk("sel2_valid", 32'(if0.out_valid), 1);

      // Select sweep, back to back
      s_dados = 16'h4321; s_vld = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         s_chave = 2'(i);
         cycle();
         chk("sweep_dados", 32'(if0.out_dados), i + 1);
         chk("sweep_valid", 32'(if0.out_valid), 1);
      end

      // Stall three cycles: word held, nothing accepted
      s_ordy = 1'b0; s_chave = 2'd0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_dados", 32'(if0.out_dados), 4);
         chk("bp_ready", 32'(if0.in_ready), 0);
      end
      s_ordy = 1'b1;
      cycle();
      chk("bp_next_dados", 32'(if0.out_dados), 1);
      chk("bp_next_valid", 32'(if0.out_valid), 1);

      // Reset mid-stream with a full output register
      do_reset_async();

      // Round-robin from ptr=0 over channels 0 and 3, then all channels with wrap
      exp_a = '{0, 3, 0, 3};
      s_vld = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         s_dados = 16'($urandom);
         cycle();
         chk("rr1001_canal", 32'(if1.out_canal), exp_a[i]);
      end
      exp_b = '{0, 1, 2, 3, 0, 1};
      s_vld = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         s_dados = 16'($urandom);
         cycle();
         chk("rrall_canal", 32'(if1.out_canal), exp_b[i]);
         chk("rrall_valid", 32'(if1.out_valid), 1);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         s_dados = 16'($urandom);
         s_vld   = 4'($urandom);
         s_chave = 2'($urandom);
         s_ordy  = ($urandom_range(0, 3) != 0);
         s_last  = 4'($urandom);
         cycle();
      end

`ifdef MUX_PACOTE_EN
      // Packet of three beats on channel 1 holds off channel 2
      do_reset_async();
      s_vld = 4'b0110; s_ordy = 1'b1; s_chave = 2'd1; s_dados = 16'h0900;
      for (int b = 0; b < 3; b++) begin
         s_dados[7:4] = 4'(b + 5);
         s_last = (b == 2) ? 4'b0010 : 4'b0000;
         cycle();
         chk("pkt_canal", 32'(if1.out_canal), 1);
         chk("pkt_dados", 32'(if1.out_dados), b + 5);
         chk("pkt_last", 32'(if1.out_last), (b == 2) ? 1 : 0);
      end
      s_last = 4'b0000;
      cycle();
      chk("pkt_after_canal", 32'(if1.out_canal), 2);
      chk("pkt_after_last", 32'(if1.out_last), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
